// File: rtl/srt4_control_unit.sv
// rtl/srt4_control_unit.sv - radix-4 SRT divider sequencer driving datapath pulses c0..c14
module srt4_control_unit #(
   parameter int ITER     = 4,
   parameter int NORM_MAX = 8,
   parameter int CNT_W    = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       b_msb,
   input  logic [2:0] p_top,
   input  logic       p_sign,
   output logic       c0,
   output logic       c1,
   output logic       c2,
   output logic       c3,
   output logic       c4,
   output logic       c5,
   output logic       c6,
   output logic       c7,
   output logic       c8,
   output logic       c9,
   output logic       c10,
   output logic       c11,
   output logic       c12,
   output logic       c13,
   output logic       c14,
   output logic       busy,
   output logic       done,
   output logic       div_zero
);

   typedef enum logic [3:0] {
      S_IDLE, S_INIT, S_LOADB, S_NTEST, S_NSHIFT, S_SEL, S_SHIFT, S_ADD,
      S_ITEST, S_CHECK, S_CORR, S_QUOT, S_DTEST, S_DSHIFT, S_DONE
   } state_t;

   typedef enum logic [2:0] {
      D_ZERO, D_P1, D_P2, D_M1, D_M2
   } digit_t;

   state_t           state, state_nxt;
   digit_t           digit, digit_nxt;
   logic [CNT_W-1:0] k, k_nxt;
   logic [CNT_W-1:0] i, i_nxt;
   logic             dz_q, dz_nxt;
   logic [14:0]      c_q, c_nxt;
   logic             busy_q, busy_nxt;
   logic             done_q, done_nxt;

   function automatic digit_t digit_of(input logic [2:0] p);
      case (p)
         3'b001:         digit_of = D_P1;
         3'b010, 3'b011: digit_of = D_P2;
         3'b110:         digit_of = D_M1;
         3'b100, 3'b101: digit_of = D_M2;
         default:        digit_of = D_ZERO;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         digit  <= D_ZERO;
         k      <= '0;
         i      <= '0;
         dz_q   <= 1'b0;
         c_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         digit  <= digit_nxt;
         k      <= k_nxt;
         i      <= i_nxt;
         dz_q   <= dz_nxt;
         c_q    <= c_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      digit_nxt = digit;
      k_nxt     = k;
      i_nxt     = i;
      dz_nxt    = dz_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               state_nxt = S_INIT;
               dz_nxt    = 1'b0;
            end
         end
         S_INIT: begin
            k_nxt     = '0;
            i_nxt     = '0;
            dz_nxt    = 1'b0;
            state_nxt = S_LOADB;
         end
         S_LOADB:  state_nxt = S_NTEST;
         S_NTEST: begin
            if (b_msb) begin
               state_nxt = S_SEL;
            end else if (k == CNT_W'(NORM_MAX)) begin
               state_nxt = S_DONE;
               dz_nxt    = 1'b1;
            end else begin
               state_nxt = S_NSHIFT;
            end
         end
         S_NSHIFT: begin
            k_nxt     = k + CNT_W'(1);
            state_nxt = S_NTEST;
         end
         S_SEL: begin
            digit_nxt = digit_of(p_top);
            state_nxt = S_SHIFT;
         end
         S_SHIFT: begin
            i_nxt     = i + CNT_W'(1);
            state_nxt = (digit != D_ZERO) ? S_ADD : S_ITEST;
         end
         S_ADD:    state_nxt = S_ITEST;
         S_ITEST:  state_nxt = (i == CNT_W'(ITER)) ? S_CHECK : S_SEL;
         S_CHECK:  state_nxt = p_sign ? S_CORR : S_QUOT;
         S_CORR:   state_nxt = S_QUOT;
         S_QUOT:   state_nxt = S_DTEST;
         S_DTEST:  state_nxt = (k == '0) ? S_DONE : S_DSHIFT;
         S_DSHIFT: begin
            k_nxt     = k - CNT_W'(1);
            state_nxt = S_DTEST;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each flop lines up with the state it belongs to.
   always_comb begin
      c_nxt    = '0;
      busy_nxt = (state_nxt != S_IDLE);
      done_nxt = (state_nxt == S_DONE);
      case (state_nxt)
         S_INIT:   c_nxt[0] = 1'b1;
         S_LOADB:  c_nxt[1] = 1'b1;
         S_NSHIFT: c_nxt[2] = 1'b1;
         S_SHIFT: begin
            c_nxt[3] = 1'b1;
            c_nxt[4] = (digit_nxt == D_P1);
            c_nxt[5] = (digit_nxt == D_M1);
            c_nxt[6] = (digit_nxt == D_M2);
            c_nxt[7] = (digit_nxt == D_P2);
         end
         S_ADD: begin
            c_nxt[8]  = 1'b1;
            c_nxt[9]  = (digit_nxt == D_P2) || (digit_nxt == D_M2);
            c_nxt[10] = (digit_nxt == D_P1) || (digit_nxt == D_P2);
         end
         S_CORR: begin
            c_nxt[8]  = 1'b1;
            c_nxt[12] = 1'b1;
         end
         S_QUOT: begin
            c_nxt[11] = 1'b1;
            c_nxt[13] = 1'b1;
         end
         S_DSHIFT: c_nxt[14] = 1'b1;
         default:  c_nxt = '0;
      endcase
   end

   assign c0       = c_q[0];
   assign c1       = c_q[1];
   assign c2       = c_q[2];
   assign c3       = c_q[3];
   assign c4       = c_q[4];
   assign c5       = c_q[5];
   assign c6       = c_q[6];
   assign c7       = c_q[7];
   assign c8       = c_q[8];
   assign c9       = c_q[9];
   assign c10      = c_q[10];
   assign c11      = c_q[11];
   assign c12      = c_q[12];
   assign c13      = c_q[13];
   assign c14      = c_q[14];
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = dz_q;

endmodule

// File: tb/tb_srt4_control_unit.sv
// tb/tb_srt4_control_unit.sv - directed bench for the SRT radix-4 sequencer
module tb_srt4_control_unit;

   logic       clk = 1'b0;
   logic       rst, start, b_msb, p_sign;
   logic [2:0] p_top;
   logic       c0, c1, c2, c3, c4, c5, c6, c7, c8, c9, c10, c11, c12, c13, c14;
   logic       busy, done, div_zero;
   logic [14:0] cv;

   int total = 0;
   int bad   = 0;

   logic [14:0] logc [0:255];
   int n_c2, n_c3, n_c8, n_c14, n_hi, viol, len;
   logic got_done, dz_at_done, busy_at_done;

   srt4_control_unit dut (
      .clk(clk), .rst(rst), .start(start), .b_msb(b_msb), .p_top(p_top), .p_sign(p_sign),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
      .c8(c8), .c9(c9), .c10(c10), .c11(c11), .c12(c12), .c13(c13), .c14(c14),
      .busy(busy), .done(done), .div_zero(div_zero)
   );

   assign cv = {c14, c13, c12, c11, c10, c9, c8, c7, c6, c5, c4, c3, c2, c1, c0};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Runs one division; b_msb rises after nshift c2 pulses, p_top follows the iteration count.
   task automatic run(input int nshift, input logic [11:0] pts, input logic ps, input int start_at);
      int j;
      n_c2 = 0; n_c3 = 0; n_c8 = 0; n_c14 = 0; n_hi = 0; viol = 0; len = 0;
      got_done = 1'b0; dz_at_done = 1'b0; busy_at_done = 1'b0;
      b_msb = (nshift == 0);
      p_top = pts[2:0];
      p_sign = ps;
      start = 1'b1;
      for (int cyc = 1; cyc <= 200 && !got_done; cyc++) begin
         @(posedge clk); #1;
         start = (cyc == start_at);
         logc[cyc] = cv;
         if (c2) n_c2++;
         if (c3) n_c3++;
         if (c8) n_c8++;
         if (c14) n_c14++;
         if (|cv[14:3]) n_hi++;
         if ($countones(cv[7:4]) > 1) viol++;
         if ((c9 | c10 | c11) && !(c8 | c13)) viol++;
         if (done) begin
            got_done = 1'b1;
            len = cyc;
            dz_at_done = div_zero;
            busy_at_done = busy;
         end
         b_msb = (n_c2 >= nshift);
         j = (n_c3 > 3) ? 3 : n_c3;
         p_top = pts[3*j +: 3];
      end
      start = 1'b0;
      chk("done_reached", {31'd0, got_done}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; b_msb = 1'b0; p_top = 3'b000; p_sign = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("reset_c", {17'd0, cv}, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_dz", {31'd0, div_zero}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Already normalized divisor, all-zero digits.
      run(0, 12'h000, 1'b0, 0);
      chk("a_c0_cyc1", {17'd0, logc[1]}, 32'h1);
      chk("a_c1_cyc2", {17'd0, logc[2]}, 32'h2);
      chk("a_c3_count", n_c3, 4);
      chk("a_c3_cyc5", {17'd0, logc[5]}, 32'h8);
      chk("a_c3_cyc14", {17'd0, logc[14]}, 32'h8);
      chk("a_c8_count", n_c8, 0);
      chk("a_quot_cyc17", {17'd0, logc[17]}, 32'h2800);
      chk("a_len", len, 19);
      chk("a_c2_count", n_c2, 0);
      chk("a_c14_count", n_c14, 0);
      chk("a_busy_done", {31'd0, busy_at_done}, 32'd1);
      chk("a_viol", viol, 0);
      @(posedge clk); #1;
      chk("a_idle_busy", {31'd0, busy}, 32'd0);
      chk("a_idle_done", {31'd0, done}, 32'd0);

      // Divisor never normalizes; extra start while busy is ignored.
      run(99, 12'h000, 1'b0, 5);
      chk("z_c2_count", n_c2, 8);
      chk("z_len", len, 20);
      chk("z_dz", {31'd0, dz_at_done}, 32'd1);
      chk("z_hi_count", n_hi, 0);
      @(posedge clk); #1;
      chk("z_idle_busy", {31'd0, busy}, 32'd0);

      // Three normalization shifts, denormalized by three right shifts.
      run(3, 12'h000, 1'b0, 0);
      chk("n_c2_count", n_c2, 3);
      chk("n_c14_count", n_c14, 3);
      chk("n_len", len, 31);
      chk("n_dz_cleared", {31'd0, dz_at_done}, 32'd0);
      @(posedge clk); #1;

      // Digits +2, -2, +1, -1 then negative remainder correction.
      run(0, {3'b110, 3'b001, 3'b101, 3'b011}, 1'b1, 0);
      chk("d_shift_p2", {17'd0, logc[5]}, 32'h88);
      chk("d_add_p2", {17'd0, logc[6]}, 32'h700);
      chk("d_shift_m2", {17'd0, logc[9]}, 32'h48);
      chk("d_add_m2", {17'd0, logc[10]}, 32'h300);
      chk("d_shift_p1", {17'd0, logc[13]}, 32'h18);
      chk("d_add_p1", {17'd0, logc[14]}, 32'h500);
      chk("d_shift_m1", {17'd0, logc[17]}, 32'h28);
      chk("d_add_m1", {17'd0, logc[18]}, 32'h100);
      chk("d_corr", {17'd0, logc[21]}, 32'h1100);
      chk("d_quot", {17'd0, logc[22]}, 32'h2800);
      chk("d_len", len, 24);
      chk("d_viol", viol, 0);
      @(posedge clk); #1;

      // Reset in the middle of an ADD step, then a clean restart.
      b_msb = 1'b1; p_top = 3'b011; p_sign = 1'b0; start = 1'b1;
      for (int n = 0; n < 50; n++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (c8) break;
      end
      chk("r_reach_add", {31'd0, c8}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("r_rst_c", {17'd0, cv}, 32'd0);
      chk("r_rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("r_after_c", {17'd0, cv}, 32'd0);
      chk("r_after_busy", {31'd0, busy}, 32'd0);
      chk("r_after_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
      run(0, 12'h000, 1'b0, 0);
      chk("r_restart_c0", {17'd0, logc[1]}, 32'h1);
      chk("r_restart_c1", {17'd0, logc[2]}, 32'h2);
      chk("r_restart_len", len, 19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
